// File: rtl/gate_activation_pkg.sv
// Shared fixed-point constants, FSM state encoding and log2 helper for gate_activation.
// Constants are functions of the fractional bit count so every format derives them the same way.
package gate_activation_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } act_state_t;

    function automatic int log2c(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Breakpoints and offsets of the piecewise-linear sigmoid; qm must be at least 5.
    function automatic int fx_one(input int qm);
        return 1 << qm;
    endfunction

    function automatic int fx_half(input int qm);
        return 1 << (qm - 1);
    endfunction

    function automatic int fx_bp_sat(input int qm);
        return 5 << qm;
    endfunction

    function automatic int fx_bp_mid(input int qm);
        return 19 << (qm - 3);
    endfunction

    function automatic int fx_bp_lo(input int qm);
        return 1 << qm;
    endfunction

    function automatic int fx_off_mid(input int qm);
        return 27 << (qm - 5);
    endfunction

    function automatic int fx_off_lo(input int qm);
        return 5 << (qm - 3);
    endfunction

endpackage

// File: rtl/gate_activation_if.sv
// Handshake and vector bus between the gate stage and gate_activation.
// GATE_ACT_SAT_CNT_EN adds the satCount bus member.
interface gate_activation_if #(
    parameter int HIDDEN_SZ = 64,
    parameter int QN        = 6,
    parameter int QM        = 11
);
    localparam int BITWIDTH       = QN + QM + 1;
    localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ;

    logic                      beginAct;
    logic [LAYER_BITWIDTH-1:0] gateInput;
    logic                      busy;
    logic                      dataReady_act;
    logic [LAYER_BITWIDTH-1:0] actOutput;

`ifdef GATE_ACT_SAT_CNT_EN
    logic [gate_activation_pkg::log2c(HIDDEN_SZ):0] satCount;

    modport master (output beginAct, output gateInput,
                    input busy, input dataReady_act, input actOutput, input satCount);
    modport slave  (input beginAct, input gateInput,
                    output busy, output dataReady_act, output actOutput, output satCount);
`else
    modport master (output beginAct, output gateInput,
                    input busy, input dataReady_act, input actOutput);
    modport slave  (input beginAct, input gateInput,
                    output busy, output dataReady_act, output actOutput);
`endif

endinterface

// File: rtl/gate_activation_pla_sigmoid.sv
// Single-element shift-and-add piecewise-linear sigmoid, purely combinational.
module gate_activation_pla_sigmoid
    import gate_activation_pkg::*;
#(
    parameter int QN = 6,
    parameter int QM = 11
) (
    input  logic signed [QN+QM:0] x,
    output logic signed [QN+QM:0] y,
    output logic                  sat
);
    localparam int BW = QN + QM + 1;
    localparam logic signed [BW-1:0] MAX_POS    = {1'b0, {(BW-1){1'b1}}};
    localparam logic signed [BW-1:0] MIN_NEG    = {1'b1, {(BW-1){1'b0}}};
    localparam logic signed [BW-1:0] K_ONE      = BW'(fx_one(QM));
    localparam logic signed [BW-1:0] K_HALF     = BW'(fx_half(QM));
    localparam logic signed [BW-1:0] K_BP_SAT   = BW'(fx_bp_sat(QM));
    localparam logic signed [BW-1:0] K_BP_MID   = BW'(fx_bp_mid(QM));
    localparam logic signed [BW-1:0] K_BP_LO    = BW'(fx_bp_lo(QM));
    localparam logic signed [BW-1:0] K_OFF_MID  = BW'(fx_off_mid(QM));
    localparam logic signed [BW-1:0] K_OFF_LO   = BW'(fx_off_lo(QM));

    logic signed [BW-1:0] a;
    logic signed [BW-1:0] y_pos;

    always_comb begin
        // The most negative code has no positive twin, so it saturates before region selection.
        if (x == MIN_NEG)  a = MAX_POS;
        else if (x < 0)    a = -x;
        else               a = x;

        if (a >= K_BP_SAT)      y_pos = K_ONE;
        else if (a >= K_BP_MID) y_pos = (a >>> 5) + K_OFF_MID;
        else if (a >= K_BP_LO)  y_pos = (a >>> 3) + K_OFF_LO;
        else                    y_pos = (a >>> 2) + K_HALF;

        y   = x[BW-1] ? (K_ONE - y_pos) : y_pos;
        sat = (a >= K_BP_SAT);
    end

endmodule

// File: rtl/gate_activation.sv
// Chunked activation stage: ELEMS_PER_CYCLE sigmoid/tanh evaluators sweep the captured vector.
// GATE_ACT_SAT_CNT_EN adds a per-run count of saturated evaluator inputs (satCount).
module gate_activation
    import gate_activation_pkg::*;
#(
    parameter int HIDDEN_SZ       = 64,
    parameter int QN              = 6,
    parameter int QM              = 11,
    parameter int ELEMS_PER_CYCLE = 8,
    parameter int ACT_TYPE        = 0
) (
    input logic              clock,
    input logic              reset,
    gate_activation_if.slave act
);
    localparam int BITWIDTH       = QN + QM + 1;
    localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ;
    localparam int N_CHUNKS       = HIDDEN_SZ / ELEMS_PER_CYCLE;
    localparam int CNT_BITWIDTH   = log2c(N_CHUNKS) + 1;
    localparam int CHUNK_W        = BITWIDTH * ELEMS_PER_CYCLE;
    localparam logic signed [BITWIDTH-1:0] K_ONE   = BITWIDTH'(fx_one(QM));
    localparam logic signed [BITWIDTH-1:0] SAT_POS = {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [BITWIDTH-1:0] SAT_NEG = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic signed [BITWIDTH:0]   DBL_MAX = {2'b00, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [BITWIDTH:0]   DBL_MIN = {2'b11, {(BITWIDTH-1){1'b0}}};

    act_state_t                state, next_state;
    logic [CNT_BITWIDTH-1:0]   chunk_cnt;
    logic [LAYER_BITWIDTH-1:0] snap;
    logic [LAYER_BITWIDTH-1:0] act_out;
    logic [CHUNK_W-1:0]        chunk_in;
    logic [CHUNK_W-1:0]        chunk_out;
    logic                      capture;
    logic                      write_chunk;
    logic                      last_chunk;

    assign last_chunk = (chunk_cnt == CNT_BITWIDTH'(N_CHUNKS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // beginAct outside IDLE is dropped; the upstream spaces its pulses.
    always_comb begin
        next_state  = state;
        capture     = 1'b0;
        write_chunk = 1'b0;
        unique case (state)
            IDLE: if (act.beginAct) begin
                capture    = 1'b1;
                next_state = PROC;
            end
            PROC: begin
                write_chunk = 1'b1;
                if (last_chunk) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chunk_cnt <= '0;
            snap      <= '0;
            act_out   <= '0;
        end else if (capture) begin
            chunk_cnt <= '0;
            snap      <= act.gateInput;
        end else if (write_chunk) begin
            act_out[int'(chunk_cnt)*CHUNK_W +: CHUNK_W] <= chunk_out;
            chunk_cnt <= chunk_cnt + CNT_BITWIDTH'(1);
        end
    end

    assign chunk_in = snap[int'(chunk_cnt)*CHUNK_W +: CHUNK_W];

`ifdef GATE_ACT_SAT_CNT_EN
    logic [ELEMS_PER_CYCLE-1:0] lane_sat;
`endif

    for (genvar l = 0; l < ELEMS_PER_CYCLE; l++) begin : g_lane
        logic signed [BITWIDTH-1:0] x, eval_in, s, y;

        assign x = chunk_in[l*BITWIDTH +: BITWIDTH];

        if (ACT_TYPE == 1) begin : g_tanh
            // tanh(x) = 2*sigmoid(2x) - 1, with 2x clamped back into the element range.
            logic signed [BITWIDTH:0] dbl;
            assign dbl     = {x, 1'b0};
            assign eval_in = (dbl > DBL_MAX) ? SAT_POS :
                             (dbl < DBL_MIN) ? SAT_NEG : dbl[BITWIDTH-1:0];
            assign y       = (s <<< 1) - K_ONE;
        end else begin : g_sig
            assign eval_in = x;
            assign y       = s;
        end

        gate_activation_pla_sigmoid #(.QN(QN), .QM(QM)) u_sig (
            .x   (eval_in),
            .y   (s),
`ifdef GATE_ACT_SAT_CNT_EN
            .sat (lane_sat[l])
`else
            .sat ()
`endif
        );

        assign chunk_out[l*BITWIDTH +: BITWIDTH] = y;
    end

`ifdef GATE_ACT_SAT_CNT_EN
    localparam int SAT_W = log2c(HIDDEN_SZ) + 1;
    logic [SAT_W-1:0] sat_cnt, chunk_sat;

    always_comb begin
        chunk_sat = '0;
        for (int l = 0; l < ELEMS_PER_CYCLE; l++) chunk_sat = chunk_sat + SAT_W'(lane_sat[l]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           sat_cnt <= '0;
        else if (capture)     sat_cnt <= '0;
        else if (write_chunk) sat_cnt <= sat_cnt + chunk_sat;
    end

    assign act.satCount = sat_cnt;
`endif

    assign act.busy          = (state != IDLE);
    assign act.dataReady_act = (state == DONE);
    assign act.actOutput     = act_out;

endmodule

// File: tb/tb_gate_activation.sv
// Bench for gate_activation: sigmoid and tanh instances, table vectors, random runs and corner sequences.
module tb_gate_activation;
    localparam int HS      = 64;
    localparam int BW      = 18;
    localparam int LBW     = BW * HS;
    localparam int NEG_MAX = -131072;
    localparam int POS_MAX = 131071;
    localparam int WIN     = 24;

    typedef struct {
        int idx;
        int x;
        int y;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    int xs[HS];
    logic [LBW-1:0] last_out;
`ifdef GATE_ACT_SAT_CNT_EN
    int last_sat;
`endif

    always #5 clock = ~clock;

    gate_activation_if #(.HIDDEN_SZ(HS), .QN(6), .QM(11)) sif ();
    gate_activation_if #(.HIDDEN_SZ(HS), .QN(6), .QM(11)) tif ();

    gate_activation #(.HIDDEN_SZ(HS), .QN(6), .QM(11), .ELEMS_PER_CYCLE(8), .ACT_TYPE(0)) dut_sig (
        .clock (clock),
        .reset (reset),
        .act   (sif)
    );

    gate_activation #(.HIDDEN_SZ(HS), .QN(6), .QM(11), .ELEMS_PER_CYCLE(8), .ACT_TYPE(1)) dut_tanh (
        .clock (clock),
        .reset (reset),
        .act   (tif)
    );

    // Reference: the piecewise-linear rules written directly in Q6.11 integers.
    function automatic int ref_sig(int x);
        int a, y;
        a = (x < 0) ? -x : x;
        if (a > POS_MAX) a = POS_MAX;
        if (a >= 10240)     y = 2048;
        else if (a >= 4864) y = a / 32 + 1728;
        else if (a >= 2048) y = a / 8 + 1280;
        else                y = a / 4 + 1024;
        return (x < 0) ? 2048 - y : y;
    endfunction

    function automatic int eval_of(bit th, int x);
        int d;
        if (!th) return x;
        d = 2 * x;
        if (d > POS_MAX) d = POS_MAX;
        if (d < NEG_MAX) d = NEG_MAX;
        return d;
    endfunction

    function automatic int ref_act(bit th, int x);
        return th ? (2 * ref_sig(eval_of(th, x)) - 2048) : ref_sig(x);
    endfunction

    function automatic int ref_sat(bit th, int x);
        int e;
        e = eval_of(th, x);
        return ((e >= 10240) || (e <= -10240)) ? 1 : 0;
    endfunction

    function automatic int elem(logic [LBW-1:0] v, int i);
        logic signed [BW-1:0] e;
        e = v[i*BW +: BW];
        return int'(e);
    endfunction

    function automatic int nz_count(logic [LBW-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < HS; i++) if (elem(v, i) != 0) n++;
        return n;
    endfunction

    function automatic logic [LBW-1:0] out_of(bit th);
        return th ? tif.actOutput : sif.actOutput;
    endfunction

    function automatic logic rdy_of(bit th);
        return th ? tif.dataReady_act : sif.dataReady_act;
    endfunction

    function automatic logic busy_of(bit th);
        return th ? tif.busy : sif.busy;
    endfunction

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic set_begin(bit th, logic v);
        if (th) tif.beginAct = v;
        else    sif.beginAct = v;
    endtask

    task automatic set_input(bit th, logic [LBW-1:0] v);
        if (th) tif.gateInput = v;
        else    sif.gateInput = v;
    endtask

    task automatic apply_vec(bit th);
        logic [LBW-1:0] v;
        for (int i = 0; i < HS; i++) v[i*BW +: BW] = BW'(xs[i]);
        set_input(th, v);
    endtask

    task automatic clear_xs();
        for (int i = 0; i < HS; i++) xs[i] = 0;
    endtask

    task automatic fill_random();
        int bp[6];
        int v;
        bp = '{1024, 2048, 4864, 5120, 2432, 10240};
        for (int i = 0; i < HS; i++) begin
            case ($urandom_range(0, 3))
                0: xs[i] = int'($urandom_range(0, 262143)) - 131072;
                1: xs[i] = int'($urandom_range(0, 6000)) - 3000;
                2: begin
                    v = bp[$urandom_range(0, 5)] + int'($urandom_range(0, 4)) - 2;
                    xs[i] = ($urandom_range(0, 1) != 0) ? -v : v;
                end
                default: begin
                    v = int'($urandom_range(0, 2));
                    xs[i] = (v == 0) ? NEG_MAX : (v == 1) ? POS_MAX : 0;
                end
            endcase
        end
    endtask

    // One run from the xs vector; with disturb, extra beginAct pulses and a new gateInput arrive mid-run.
    task automatic run_check(bit th, string name, bit disturb);
        int exp_v[HS];
        int exp_sat, pulses, lat, b_cnt, b_first;
        logic [LBW-1:0] alt, cap;
`ifdef GATE_ACT_SAT_CNT_EN
        int cap_sat;
        cap_sat = -1;
`endif
        exp_sat = 0; pulses = 0; lat = -1; b_cnt = 0; b_first = -1; cap = '0;
        for (int i = 0; i < HS; i++) begin
            exp_v[i] = ref_act(th, xs[i]);
            exp_sat += ref_sat(th, xs[i]);
            alt[i*BW +: BW] = BW'($urandom);
        end
        apply_vec(th);
        @(negedge clock);
        set_begin(th, 1'b1);
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clock);
            if (rdy_of(th)) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    cap = out_of(th);
`ifdef GATE_ACT_SAT_CNT_EN
                    cap_sat = th ? int'(tif.satCount) : int'(sif.satCount);
`endif
                end
            end
            if (busy_of(th)) begin
                b_cnt++;
                if (b_first < 0) b_first = k;
            end
            if (k == 1) set_begin(th, 1'b0);
            if (disturb) begin
                if (k == 3) begin
                    set_input(th, alt);
                    set_begin(th, 1'b1);
                end
                if (k == 4)  set_begin(th, 1'b0);
                if (k == 9)  set_begin(th, 1'b1);
                if (k == 10) set_begin(th, 1'b0);
            end
        end
        check($sformatf("%s ready_pulses", name), pulses, 1);
        check($sformatf("%s ready_edge", name), lat, 9);
        check($sformatf("%s busy_first", name), b_first, 1);
        check($sformatf("%s busy_cycles", name), b_cnt, 9);
        for (int i = 0; i < HS; i++)
            check($sformatf("%s elem%0d", name, i), elem(cap, i), exp_v[i]);
`ifdef GATE_ACT_SAT_CNT_EN
        check($sformatf("%s satCount", name), cap_sat, exp_sat);
        last_sat = cap_sat;
`endif
        last_out = cap;
    endtask

    initial begin
        vec_t sig_tab[5];
        vec_t tanh_tab[4];
        int pulses;
        sig_tab[0]  = '{6, 2048, 1536};
        sig_tab[1]  = '{13, -2048, 512};
        sig_tab[2]  = '{27, 4864, 1880};
        sig_tab[3]  = '{40, 12288, 2048};
        sig_tab[4]  = '{63, NEG_MAX, 0};
        tanh_tab[0] = '{0, 0, 0};
        tanh_tab[1] = '{21, 1024, 1024};
        tanh_tab[2] = '{35, -1024, -1024};
        tanh_tab[3] = '{58, 8192, 2048};

        sif.beginAct = 1'b0; sif.gateInput = '0;
        tif.beginAct = 1'b0; tif.gateInput = '0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset sig busy", int'(sif.busy), 0);
        check("reset sig ready", int'(sif.dataReady_act), 0);
        check("reset sig out_nonzero", nz_count(sif.actOutput), 0);
        check("reset tanh busy", int'(tif.busy), 0);
        check("reset tanh ready", int'(tif.dataReady_act), 0);
        check("reset tanh out_nonzero", nz_count(tif.actOutput), 0);
`ifdef GATE_ACT_SAT_CNT_EN
        check("reset satCount", int'(sif.satCount), 0);
`endif
        reset = 1'b1;

        clear_xs();
        run_check(1'b0, "zero_sig", 1'b0);
        for (int i = 0; i < HS; i++) check($sformatf("zero_sig half elem%0d", i), elem(last_out, i), 1024);

        clear_xs();
        for (int j = 0; j < 5; j++) xs[sig_tab[j].idx] = sig_tab[j].x;
        run_check(1'b0, "tab_sig", 1'b0);
        for (int j = 0; j < 5; j++)
            check($sformatf("tab_sig x=%0d", sig_tab[j].x), elem(last_out, sig_tab[j].idx), sig_tab[j].y);

        clear_xs();
        for (int j = 0; j < 4; j++) xs[tanh_tab[j].idx] = tanh_tab[j].x;
        run_check(1'b1, "tab_tanh", 1'b0);
        for (int j = 0; j < 4; j++)
            check($sformatf("tab_tanh x=%0d", tanh_tab[j].x), elem(last_out, tanh_tab[j].idx), tanh_tab[j].y);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_check(1'b0, $sformatf("rand_sig%0d", r), 1'b0);
            fill_random();
            run_check(1'b1, $sformatf("rand_tanh%0d", r), 1'b0);
        end

        fill_random();
        run_check(1'b0, "disturb_sig", 1'b1);
        fill_random();
        run_check(1'b1, "disturb_tanh", 1'b1);

        // Reset pulled just before the fourth chunk edge of a sigmoid run.
        for (int i = 0; i < HS; i++) xs[i] = i * 100;
        apply_vec(1'b0);
        @(negedge clock);
        set_begin(1'b0, 1'b1);
        @(negedge clock);
        set_begin(1'b0, 1'b0);
        repeat (2) @(negedge clock);
        check("midrst partial elem0", elem(sif.actOutput, 0), 1024);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst out_nonzero", nz_count(sif.actOutput), 0);
        check("midrst busy", int'(sif.busy), 0);
        check("midrst ready", int'(sif.dataReady_act), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (sif.dataReady_act) pulses++;
        end
        check("midrst ready_pulses", pulses, 0);
        check("midrst out_after", nz_count(sif.actOutput), 0);
        fill_random();
        run_check(1'b0, "post_rst", 1'b0);

`ifdef GATE_ACT_SAT_CNT_EN
        clear_xs();
        xs[1] = 10240;  xs[7] = -10240; xs[13] = 12288; xs[19] = NEG_MAX; xs[25] = POS_MAX;
        xs[31] = 20000; xs[37] = -20000; xs[43] = 10241; xs[49] = -10241; xs[55] = 50000;
        xs[60] = 10239;
        run_check(1'b0, "sat_sig", 1'b0);
        check("sat_sig count10", last_sat, 10);
        clear_xs();
        run_check(1'b0, "sat_zero", 1'b0);
        check("sat_zero count0", last_sat, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
